// File: rtl/cache_line_fill_writer_pkg.sv
// Shared types for the cache line fill writer.
package cache_line_fill_writer_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2
    } fill_state_t;

endpackage : cache_line_fill_writer_pkg

// File: rtl/cache_line_fill_writer_if.sv
// Fill request, memory beat, RAM port B and status signals of the fill writer.
interface cache_line_fill_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LINE_W     = 8
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OFF_W  = $clog2(LINE_W);
    localparam int IDX_W  = ADDR_W - OFF_W;

    logic                  fill_start;
    logic [IDX_W-1:0]      fill_index;
    logic [OFF_W-1:0]      fill_offset;
    logic                  fill_ready;
    logic                  beat_valid;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_ready;
    logic                  ram_en_b;
    logic                  ram_we_b;
    logic [ADDR_W-1:0]     ram_addr_b;
    logic [DATA_WIDTH-1:0] ram_data_b;
    logic                  crit_valid;
    logic [DATA_WIDTH-1:0] crit_data;
    logic                  fill_done;
    logic                  init_done;

    // The fill writer itself.
    modport slave (
        input  fill_start, fill_index, fill_offset, beat_valid, beat_data,
        output fill_ready, beat_ready, ram_en_b, ram_we_b, ram_addr_b, ram_data_b,
               crit_valid, crit_data, fill_done, init_done
    );

    // Requester / memory side.
    modport master (
        output fill_start, fill_index, fill_offset, beat_valid, beat_data,
        input  fill_ready, beat_ready, ram_en_b, ram_we_b, ram_addr_b, ram_data_b,
               crit_valid, crit_data, fill_done, init_done
    );

endinterface : cache_line_fill_writer_if

// File: rtl/cache_line_fill_writer.sv
// Drives port B of the line RAM: zero sweep after reset, then critical-word-first
// line fills with offset wrap-around inside the line.
module cache_line_fill_writer
    import cache_line_fill_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LINE_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    cache_line_fill_writer_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int OFF_W  = $clog2(LINE_W);
    localparam int IDX_W  = ADDR_W - OFF_W;

    fill_state_t           state_q, state_d;
    logic [ADDR_W-1:0]     sweep_q;
    logic [IDX_W-1:0]      index_q;
    logic [OFF_W-1:0]      offset_q;
    logic [OFF_W-1:0]      beat_cnt_q;
    logic                  crit_valid_q;
    logic                  fill_done_q;
    logic [DATA_WIDTH-1:0] crit_data_q;

    logic                  ram_en, ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  fill_ready, beat_ready;
    logic                  beat_fire, first_beat, last_beat;

    assign beat_fire  = (state_q == ST_FILL) && bus.beat_valid;
    assign first_beat = beat_fire && (beat_cnt_q == '0);
    assign last_beat  = beat_fire && (beat_cnt_q == OFF_W'(LINE_W - 1));

    // NOTE: every output of this block gets a default before the case so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_data   = '0;
        fill_ready = 1'b0;
        beat_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = sweep_q;
                if (sweep_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                fill_ready = 1'b1;
                if (bus.fill_start) state_d = ST_FILL;
            end
            ST_FILL: begin
                beat_ready = 1'b1;
                if (bus.beat_valid) begin
                    // Write lands on this edge; the RAM is write-first.
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = {index_q, offset_q};
                    ram_data = bus.beat_data;
                    if (last_beat) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            index_q      <= '0;
            offset_q     <= '0;
            beat_cnt_q   <= '0;
            crit_valid_q <= 1'b0;
            fill_done_q  <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            crit_valid_q <= first_beat;
            fill_done_q  <= last_beat;
            if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
            if (state_q == ST_IDLE && bus.fill_start) begin
                index_q    <= bus.fill_index;
                offset_q   <= bus.fill_offset;
                beat_cnt_q <= '0;
            end
            if (beat_fire) begin
                // Offset wraps naturally at LINE_W, keeping beats inside the line.
                offset_q   <= offset_q + 1'b1;
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (first_beat) crit_data_q <= bus.beat_data;
        end
    end

    assign bus.ram_en_b   = ram_en;
    assign bus.ram_we_b   = ram_we;
    assign bus.ram_addr_b = ram_addr;
    assign bus.ram_data_b = ram_data;
    assign bus.fill_ready = fill_ready;
    assign bus.beat_ready = beat_ready;
    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_data  = crit_data_q;
    assign bus.fill_done  = fill_done_q;
    assign bus.init_done  = (state_q != ST_INIT);

endmodule : cache_line_fill_writer

// File: tb/tb_cache_line_fill_writer.sv
// Scoreboard bench for cache_line_fill_writer: expected RAM writes, critical words
// and fill completions are queued at issue time and popped by a negedge monitor.
module tb_cache_line_fill_writer;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int LINE_W = 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int OW     = $clog2(LINE_W);
    localparam int IW     = AW - OW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_line_fill_writer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LINE_W(LINE_W)) bus ();

    cache_line_fill_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t           wr_q[$];
    logic [DW-1:0] crit_q[$];
    int            done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    // Monitor: every observed event must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we_b && !bus.ram_en_b) unexpected("we_without_en", 64'(bus.ram_we_b));
            if (bus.ram_en_b) begin
                if (wr_q.size() == 0) unexpected("unexpected_write_addr", 64'(bus.ram_addr_b));
                else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_we", 64'(bus.ram_we_b), 64'd1);
                    check("wr_addr", 64'(bus.ram_addr_b), 64'(e.addr));
                    check("wr_data", 64'(bus.ram_data_b), 64'(e.data));
                end
            end
            if (bus.crit_valid) begin
                if (crit_q.size() == 0) unexpected("unexpected_crit", 64'(bus.crit_data));
                else check("crit_data", 64'(bus.crit_data), 64'(crit_q.pop_front()));
            end
            if (bus.fill_done) begin
                if (done_q.size() == 0) unexpected("unexpected_fill_done", 64'(bus.fill_done));
                else begin
                    void'(done_q.pop_front());
                    check("fill_ready_with_done", 64'(bus.fill_ready), 64'd1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset, releases it and follows the zero sweep; optionally drives junk
    // requests and beats during the sweep, which must have no effect.
    task automatic do_reset(input bit jiggle);
        rst = 1'b1;
        bus.fill_start = 1'b0;
        bus.beat_valid = 1'b0;
        step();
        step();
        wr_q.delete();
        crit_q.delete();
        done_q.delete();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) wr_q.push_back('{addr: AW'(a), data: '0});
        check("rst_fill_ready", 64'(bus.fill_ready), 64'd0);
        check("rst_beat_ready", 64'(bus.beat_ready), 64'd0);
        check("rst_init_done", 64'(bus.init_done), 64'd0);
        check("rst_crit_valid", 64'(bus.crit_valid), 64'd0);
        check("rst_crit_data", 64'(bus.crit_data), 64'd0);
        check("rst_fill_done", 64'(bus.fill_done), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            if (jiggle && k < DEPTH - 1) begin
                bus.fill_start  = 1'b1;
                bus.fill_index  = IW'($urandom);
                bus.fill_offset = OW'($urandom);
                bus.beat_valid  = 1'b1;
                bus.beat_data   = $urandom;
            end else begin
                bus.fill_start = 1'b0;
                bus.beat_valid = 1'b0;
            end
            if (k == DEPTH - 1) check("init_done_before_end", 64'(bus.init_done), 64'd0);
            step();
        end
        check("init_done_after_sweep", 64'(bus.init_done), 64'd1);
        check("fill_ready_after_sweep", 64'(bus.fill_ready), 64'd1);
        check("beat_ready_after_sweep", 64'(bus.beat_ready), 64'd0);
    endtask

    // Issues one fill. gaps[k] bubbles precede beat k; during bubbles a stray
    // fill_start is presented. n_beats < LINE_W leaves the fill unfinished.
    task automatic do_fill(input int idx, input int off, input logic [DW-1:0] d [LINE_W],
                           input int gaps [LINE_W], input int n_beats);
        int budget;
        budget = 0;
        while (!bus.fill_ready && budget < 50) begin
            step();
            budget++;
        end
        if (!bus.fill_ready) begin
            unexpected("fill_ready_timeout", 64'(budget));
            return;
        end
        bus.fill_start  = 1'b1;
        bus.fill_index  = IW'(idx);
        bus.fill_offset = OW'(off);
        step();
        bus.fill_start = 1'b0;
        check("beat_ready_after_accept", 64'(bus.beat_ready), 64'd1);
        check("fill_ready_after_accept", 64'(bus.fill_ready), 64'd0);
        for (int k = 0; k < n_beats; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                bus.beat_valid  = 1'b0;
                bus.fill_start  = 1'b1;
                bus.fill_index  = IW'($urandom);
                bus.fill_offset = OW'($urandom);
                step();
            end
            bus.fill_start = 1'b0;
            bus.beat_valid = 1'b1;
            bus.beat_data  = d[k];
            wr_q.push_back('{addr: AW'(idx * LINE_W + (off + k) % LINE_W), data: d[k]});
            if (k == 0) crit_q.push_back(d[0]);
            if (k == LINE_W - 1) done_q.push_back(idx);
            step();
        end
        bus.beat_valid = 1'b0;
        if (n_beats == LINE_W) check("fill_ready_after_last", 64'(bus.fill_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] d [LINE_W];
        int            gz [LINE_W];
        int            gp [LINE_W];
        gz = '{0, 0, 0, 0};
        bus.fill_start  = 1'b0;
        bus.fill_index  = '0;
        bus.fill_offset = '0;
        bus.beat_valid  = 1'b0;
        bus.beat_data   = '0;

        do_reset(1'b0);

        d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        do_fill(2, 0, d, gz, LINE_W);
        step();

        d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        do_fill(3, 2, d, gz, LINE_W);
        step();

        // Beat pattern 1,0,0,1,1,0,1; the next fill starts in the fill_done cycle.
        gp = '{0, 2, 0, 1};
        do_fill(3, 2, d, gp, LINE_W);
        d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        do_fill(0, 3, d, gz, LINE_W);
        step();

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < LINE_W; k++) begin
                d[k]  = $urandom;
                gp[k] = $urandom_range(0, 2);
            end
            do_fill($urandom_range(0, DEPTH / LINE_W - 1), $urandom_range(0, LINE_W - 1),
                    d, gp, LINE_W);
            if ($urandom_range(0, 1) == 1) step();
        end
        step();

        // Reset after the second beat: fill abandoned, sweep restarts with junk inputs.
        d = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        do_fill(1, 1, d, gz, 2);
        bus.beat_valid = 1'b1;
        do_reset(1'b1);

        d = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
        do_fill(1, 3, d, gz, LINE_W);

        for (int k = 0; k < 4; k++) step();
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        check("crit_queue_drained", 64'(crit_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_cache_line_fill_writer
